fetch_ctrl: RTL and testbench

- Sequences the pipelined fetch stage: owns the PC, the instruction-memory request handshake, start/branch redirects, halt and decode back-pressure.
- Sits between execute (branch/halt), decode (stall, consumes instruction) and instruction memory.
- Emits a one-cycle squash mask to the younger pipeline stages on every redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// default widths and the squash mask driven on every redirect.
package fetch_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 16;
    localparam int FLUSH_DEPTH_DEF = 2;
    localparam int COUNT_W         = 16;

    localparam logic [FLUSH_DEPTH_DEF-1:0] FLUSH_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory requests and
// handles start/branch redirects, halt and decode back-pressure.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      start_address_i,
    input  logic                   branch_i,
    input  logic [ADDR_W-1:0]      branchloc_i,
    input  logic                   halt_i,
    input  logic                   stall_i,
    output logic                   imem_req_o,
    output logic [ADDR_W-1:0]      imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [DATA_W-1:0]      imem_data_i,
    output logic [ADDR_W-1:0]      pc_o,
    output logic [DATA_W-1:0]      inst_o,
    output logic [ADDR_W-1:0]      inst_pc_o,
    output logic                   inst_valid_o,
    output logic [FLUSH_DEPTH-1:0] flush_o,
    output logic [COUNT_W-1:0]     fetch_count_o,
    output logic [1:0]             state_o
);

    fetch_state_e state_q;
    logic         transfer;

    // Any redirect, halt or stall this cycle suppresses the request outright.
    assign imem_req_o  = (state_q == ST_FETCH) & ~stall_i & ~start_i & ~branch_i & ~halt_i;
    assign imem_addr_o = pc_o;
    assign transfer    = imem_req_o & imem_ack_i;
    assign state_o     = state_q;

    // NOTE: every register, datapath included, is reset so outputs are defined immediately after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            flush_o      <= '0;
        end else begin
            flush_o <= '0;
            if (start_i) begin
                state_q      <= ST_FETCH;
                pc_o         <= start_address_i;
                flush_o      <= '1;
                inst_valid_o <= 1'b0;
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (branch_i) begin
                            pc_o         <= branchloc_i;
                            flush_o      <= '1;
                            inst_valid_o <= 1'b0;
                        end else if (halt_i) begin
                            state_q      <= ST_HALT;
                            inst_valid_o <= 1'b0;
                        end else if (!stall_i) begin
                            if (transfer) begin
                                inst_o       <= imem_data_i;
                                inst_pc_o    <= pc_o;
                                inst_valid_o <= 1'b1;
                                pc_o         <= pc_o + ADDR_W'(1);
                            end else begin
                                inst_valid_o <= 1'b0;
                            end
                        end
                    end
                    ST_IDLE, ST_HALT: begin
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        inst_valid_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_fetch_count (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (transfer),
        .count (fetch_count_o)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] start_address_i;
    logic        branch_i;
    logic [15:0] branchloc_i;
    logic        halt_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic [15:0] pc_o;
    logic [15:0] inst_o;
    logic [15:0] inst_pc_o;
    logic        inst_valid_o;
    logic [1:0]  flush_o;
    logic [15:0] fetch_count_o;
    logic [1:0]  state_o;

    fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .start_address_i (start_address_i),
        .branch_i        (branch_i),
        .branchloc_i     (branchloc_i),
        .halt_i          (halt_i),
        .stall_i         (stall_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_valid_o    (inst_valid_o),
        .flush_o         (flush_o),
        .fetch_count_o   (fetch_count_o),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Behavioural model: "running" means fetching, "halted" means parked until start.
    bit          m_running;
    bit          m_halted;
    int unsigned m_pc;
    int unsigned m_inst;
    int unsigned m_inst_pc;
    bit          m_valid;
    int unsigned m_flush;
    int unsigned m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_running = 0;
        m_halted  = 0;
        m_pc      = 0;
        m_inst    = 0;
        m_inst_pc = 0;
        m_valid   = 0;
        m_flush   = 0;
        m_count   = 0;
    endfunction

    function automatic int unsigned model_state();
        if (m_halted)  return 2;
        if (m_running) return 1;
        return 0;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_pc"},    pc_o,          m_pc);
        check({tag, "_inst"},  inst_o,        m_inst);
        check({tag, "_ipc"},   inst_pc_o,     m_inst_pc);
        check({tag, "_valid"}, inst_valid_o,  m_valid);
        check({tag, "_flush"}, flush_o,       m_flush);
        check({tag, "_count"}, fetch_count_o, m_count);
        check({tag, "_state"}, state_o,       model_state());
    endtask

    // One clock cycle: drive inputs after negedge, check the combinational
    // request, advance the model across the edge, then check registers.
    task automatic step(input string tag, input bit st, input logic [15:0] sa,
                        input bit br, input logic [15:0] bl, input bit hl,
                        input bit sl, input bit ak);
        bit          exp_req;
        logic [15:0] data;
        data            = 16'($urandom);
        start_i         = st;
        start_address_i = sa;
        branch_i        = br;
        branchloc_i     = bl;
        halt_i          = hl;
        stall_i         = sl;
        imem_ack_i      = ak;
        imem_data_i     = data;
        exp_req = m_running && !st && !br && !hl && !sl;
        #1;
        check({tag, "_req"},  imem_req_o,  exp_req);
        check({tag, "_addr"}, imem_addr_o, m_pc);
        @(posedge clk);
        m_flush = 0;
        if (st) begin
            m_pc = sa; m_running = 1; m_halted = 0; m_flush = 3; m_valid = 0;
        end else if (m_running && br) begin
            m_pc = bl; m_flush = 3; m_valid = 0;
        end else if (m_running && hl) begin
            m_running = 0; m_halted = 1; m_valid = 0;
        end else if (m_running && sl) begin
            // decode back-pressure: everything holds
        end else if (exp_req && ak) begin
            m_inst = data; m_inst_pc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % 65536;
            if (m_count < 65535) m_count++;
        end else if (m_running) begin
            m_valid = 0;
        end
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input bit sl, input bit ak);
        step(tag, 0, 16'h0, 0, 16'h0, 0, sl, ak);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start_i = 0; start_address_i = '0; branch_i = 0; branchloc_i = '0;
        halt_i = 0; stall_i = 0; imem_ack_i = 0; imem_data_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_regs("reset");
        check("reset_req", imem_req_o, 1'b0);
        rst_n = 1'b1;

        // 1: start at 0x0010, ack tied high
        step("t1_start", 1, 16'h0010, 0, 16'h0, 0, 0, 1);
        check("t1_flush_lit", flush_o, 2'b11);
        run("t1_a", 0, 1);
        check("t1_ipc_lit", inst_pc_o, 16'h0010);
        run("t1_b", 0, 1);
        run("t1_c", 0, 1);
        check("t1_count_lit", fetch_count_o, 16'd3);
        check("t1_flush_gone", flush_o, 2'b00);

        // 2: branch while running at 0x0020
        step("t2_start", 1, 16'h001F, 0, 16'h0, 0, 0, 1);
        run("t2_run", 0, 1);
        check("t2_pc_lit", pc_o, 16'h0020);
        step("t2_branch", 0, 16'h0, 1, 16'h0100, 0, 0, 1);
        check("t2_pc_tgt", pc_o, 16'h0100);
        check("t2_valid", inst_valid_o, 1'b0);
        run("t2_after", 0, 1);
        check("t2_ipc_tgt", inst_pc_o, 16'h0100);

        // 3: three-cycle stall at 0x0030
        step("t3_start", 1, 16'h002F, 0, 16'h0, 0, 0, 1);
        run("t3_run", 0, 1);
        for (int i = 0; i < 3; i++) run("t3_stall", 1, 1);
        check("t3_pc_held", pc_o, 16'h0030);
        check("t3_valid_held", inst_valid_o, 1'b1);
        run("t3_resume", 0, 1);
        check("t3_ipc_resume", inst_pc_o, 16'h0030);

        // 4: ack withheld for 4 cycles at 0x0040
        step("t4_start", 1, 16'h003F, 0, 16'h0, 0, 0, 1);
        run("t4_run", 0, 1);
        for (int i = 0; i < 4; i++) run("t4_wait", 0, 0);
        check("t4_pc_held", pc_o, 16'h0040);
        run("t4_ack", 0, 1);
        check("t4_valid_lit", inst_valid_o, 1'b1);
        check("t4_pc_lit", pc_o, 16'h0041);

        // 5: PC wrap, halt, branch ignored while halted, restart
        step("t5_start", 1, 16'hFFFE, 0, 16'h0, 0, 0, 1);
        run("t5_a", 0, 1);
        run("t5_b", 0, 1);
        check("t5_wrap_lit", pc_o, 16'h0000);
        run("t5_c", 0, 1);
        check("t5_ipc_lit", inst_pc_o, 16'h0000);
        step("t5_halt", 0, 16'h0, 0, 16'h0, 1, 0, 1);
        check("t5_state_lit", state_o, 2'd2);
        step("t5_br_halt", 0, 16'h0, 1, 16'h0BAD, 0, 0, 1);
        run("t5_halted", 0, 1);
        step("t5_restart", 1, 16'h0005, 0, 16'h0, 0, 0, 1);
        run("t5_resumed", 0, 1);
        check("t5_ipc_restart", inst_pc_o, 16'h0005);

        // 6: asynchronous reset mid-transfer
        start_i = 0; branch_i = 0; halt_i = 0; stall_i = 0; imem_ack_i = 1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("t6_async");
        check("t6_req", imem_req_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run("t6_idle", 0, 1);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            step("rnd",
                 ($urandom_range(0, 39) == 0), 16'($urandom),
                 ($urandom_range(0, 19) == 0), 16'($urandom),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
